gate_vector_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 32 +++
 rtl/gate_ref_model.sv | 12 +
 rtl/gate_vector_checker.sv | 137 +++++++++++++
 tb/tb_gate_vector_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types, bit positions and golden model for the gate vector checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } chk_state_e;

    localparam int IDX_AND  = 5;
    localparam int IDX_OR   = 4;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_XOR  = 1;
    localparam int IDX_XNOR = 0;

    localparam int NUM_VEC = 4;

    function automatic logic [5:0] gate_expected(input logic a, input logic b);
        logic [5:0] word;
        word           = '0;
        word[IDX_AND]  = a & b;
        word[IDX_OR]   = a | b;
        word[IDX_NAND] = ~(a & b);
        word[IDX_NOR]  = ~(a | b);
        word[IDX_XOR]  = a ^ b;
        word[IDX_XNOR] = ~(a ^ b);
        return word;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the two-input gate block, reusable by other checkers.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [5:0] expected_o
);

    assign expected_o = gate_expected(a_i, b_i);

endmodule

// File: rtl/gate_vector_checker.sv
// Drives all four a/b combinations onto the gate block, compares the sampled
// results against the golden model and reports per-vector failures and a verdict.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [5:0]       gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_mask
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [1:0]       VEC_LAST  = 2'(NUM_VEC - 1);

    chk_state_e       state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic             a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic [5:0]       expected;
    logic             mismatch;
    logic             driving;

    gate_ref_model u_ref (
        .a_i        (vec_q[1]),
        .b_i        (vec_q[0]),
        .expected_o (expected)
    );

    assign mismatch = (gate_out != expected);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    vec_d   = 2'd0;
                    hold_d  = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_d[vec_q] = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 2'd1;
                    hold_d  = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they leave a register.
        driving = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        a_d     = driving & vec_d[1];
        b_d     = driving & vec_d[0];
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'd0;
            hold_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: two checker instances (HOLD_CYCLES 4 and 1) around a behavioural
// gate block with selectable faults.
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       startA, startB;
    logic       aA, bA, busyA, doneA, passA;
    logic       aB, bB, busyB, doneB, passB;
    logic [2:0] errA, errB;
    logic [3:0] maskA, maskB;
    logic [5:0] goA, goB;
    int         modeA, modeB;
    int         assertCount = 0;
    int         failCount = 0;

    always #5 clk = ~clk;

    // Behavioural all_gates: mode 1 = nand stuck at 0, mode 2 = xor/xnor swapped.
    function automatic logic [5:0] gates(input logic ga, input logic gb, input int mode);
        logic [5:0] g;
        g = {ga & gb, ga | gb, ~(ga & gb), ~(ga | gb), ga ^ gb, ~(ga ^ gb)};
        if (mode == 1)      g[3] = 1'b0;
        else if (mode == 2) g[1:0] = {g[0], g[1]};
        return g;
    endfunction

    assign goA = gates(aA, bA, modeA);
    assign goB = gates(aB, bB, modeB);

    gate_vector_checker #(.HOLD_CYCLES(4), .ERR_W(3)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .a(aA), .b(bA), .gate_out(goA),
        .busy(busyA), .done(doneA), .pass(passA), .err_count(errA), .fail_mask(maskA)
    );

    gate_vector_checker #(.HOLD_CYCLES(1), .ERR_W(3)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .a(aB), .b(bB), .gate_out(goB),
        .busy(busyB), .done(doneB), .pass(passB), .err_count(errB), .fail_mask(maskB)
    );

    function automatic logic [31:0] busyOf(input bit sel); return sel ? 32'(busyB) : 32'(busyA); endfunction
    function automatic logic [31:0] doneOf(input bit sel); return sel ? 32'(doneB) : 32'(doneA); endfunction
    function automatic logic [31:0] passOf(input bit sel); return sel ? 32'(passB) : 32'(passA); endfunction
    function automatic logic [31:0] abOf(input bit sel);   return sel ? 32'({aB, bB}) : 32'({aA, bA}); endfunction
    function automatic logic [31:0] errOf(input bit sel);  return sel ? 32'(errB) : 32'(errA); endfunction
    function automatic logic [31:0] maskOf(input bit sel); return sel ? 32'(maskB) : 32'(maskA); endfunction

    task automatic setStart(input bit sel, input logic v);
        if (sel) startB = v;
        else     startA = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete run: accept, wait (bounded) for done, check verdict and return to idle.
    task automatic applyStimulus(input bit sel, input bit holdStart, input int expCycles,
                                 input bit expPass, input int expErr, input int expMask,
                                 input string tag);
        int n;
        bit seen;
        @(negedge clk);
        setStart(sel, 1'b1);
        @(posedge clk);
        #1;
        checkOutput({tag, ":busy_on_accept"}, busyOf(sel), 1);
        checkOutput({tag, ":ab_on_accept"}, abOf(sel), 0);
        checkOutput({tag, ":err_cleared"}, errOf(sel), 0);
        checkOutput({tag, ":mask_cleared"}, maskOf(sel), 0);
        checkOutput({tag, ":pass_cleared"}, passOf(sel), 0);
        if (!holdStart) setStart(sel, 1'b0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (doneOf(sel) == 1) seen = 1'b1;
        end
        checkOutput({tag, ":done_cycle"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(expCycles));
        checkOutput({tag, ":busy_in_done"}, busyOf(sel), 1);
        checkOutput({tag, ":ab_in_done"}, abOf(sel), 0);
        checkOutput({tag, ":pass"}, passOf(sel), 32'(expPass));
        checkOutput({tag, ":err_count"}, errOf(sel), 32'(expErr));
        checkOutput({tag, ":fail_mask"}, maskOf(sel), 32'(expMask));
        @(posedge clk);
        #1;
        checkOutput({tag, ":done_pulse_end"}, doneOf(sel), 0);
        checkOutput({tag, ":idle_after_done"}, busyOf(sel), 0);
        checkOutput({tag, ":pass_held"}, passOf(sel), 32'(expPass));
        setStart(sel, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({tag, ":no_restart"}, busyOf(sel), 0);
    endtask

    initial begin
        bit doneDuringReset;
        rst_n  = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        modeA  = 0;
        modeB  = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset:a", 32'(aA), 0);
        checkOutput("reset:b", 32'(bA), 0);
        checkOutput("reset:busy", 32'(busyA), 0);
        checkOutput("reset:done", 32'(doneA), 0);
        checkOutput("reset:pass", 32'(passA), 0);
        checkOutput("reset:err", 32'(errA), 0);
        checkOutput("reset:mask", 32'(maskA), 0);
        checkOutput("reset:busyB", 32'(busyB), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle:busy", 32'(busyA), 0);

        modeA = 0;
        applyStimulus(1'b0, 1'b0, 20, 1'b1, 0, 4'b0000, "good_h4");
        modeA = 1;
        applyStimulus(1'b0, 1'b0, 20, 1'b0, 3, 4'b0111, "nand_sa0");
        modeA = 2;
        applyStimulus(1'b0, 1'b0, 20, 1'b0, 4, 4'b1111, "xor_swap");
        modeA = 0;
        applyStimulus(1'b0, 1'b1, 20, 1'b1, 0, 4'b0000, "held_start");

        // Abort a faulty run during vector 2 DRIVE with an asynchronous reset.
        modeA = 1;
        @(negedge clk);
        startA = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort:ab_vec2", 32'({aA, bA}), 32'b10);
        checkOutput("abort:err_midrun", 32'(errA), 2);
        checkOutput("abort:mask_midrun", 32'(maskA), 4'b0011);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort:busy", 32'(busyA), 0);
        checkOutput("abort:ab", 32'({aA, bA}), 0);
        checkOutput("abort:err", 32'(errA), 0);
        checkOutput("abort:mask", 32'(maskA), 0);
        checkOutput("abort:pass", 32'(passA), 0);
        doneDuringReset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (doneA) doneDuringReset = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (doneA) doneDuringReset = 1'b1;
        end
        checkOutput("abort:no_done", 32'(doneDuringReset), 0);
        modeA = 0;
        applyStimulus(1'b0, 1'b0, 20, 1'b1, 0, 4'b0000, "after_abort");

        modeB = 0;
        applyStimulus(1'b1, 1'b0, 8, 1'b1, 0, 4'b0000, "good_h1");
        modeB = 1;
        applyStimulus(1'b1, 1'b0, 8, 1'b0, 3, 4'b0111, "nand_sa0_h1");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
